// File: rtl/move_collector_if.sv
// Bundle between the move collector, the 64-square generator array and the
// downstream move consumer. master = collector side, slave = array/consumer side.
interface move_collector_if #(
    parameter int NUM_SQ = 64,
    parameter int MOVE_W = 19,
    parameter int FIFO_W = 160
);
    localparam int SEL_W = $clog2(NUM_SQ);

    logic                start;
    logic                busy;
    logic                gen_done;
    logic                timeout;
    logic [8:0]          move_count;
    logic                sq_reset;
    logic [NUM_SQ-1:0]   sq_done;
    logic [NUM_SQ-1:0]   sq_fifo_empty;
    logic [SEL_W-1:0]    sq_sel;
    logic [NUM_SQ-1:0]   sq_rden;
    logic [FIFO_W-1:0]   sq_fifo_q;
    logic                mv_valid;
    logic [MOVE_W-1:0]   mv_data;
    logic                mv_ready;

    modport master (
        input  start, sq_done, sq_fifo_empty, sq_fifo_q, mv_ready,
        output busy, gen_done, timeout, move_count, sq_reset, sq_sel, sq_rden,
               mv_valid, mv_data
    );

    modport slave (
        output start, sq_done, sq_fifo_empty, sq_fifo_q, mv_ready,
        input  busy, gen_done, timeout, move_count, sq_reset, sq_sel, sq_rden,
               mv_valid, mv_data
    );
endinterface

// File: rtl/move_collector.sv
// Runs one ply of move generation: resets the square array, waits for done
// (with watchdog), then drains every square FIFO and streams the valid moves.
module move_collector #(
    parameter int NUM_SQ   = 64,
    parameter int MOVE_W   = 19,
    parameter int SLOTS    = 8,
    parameter int FIFO_W   = 160,
    parameter int WAIT_MAX = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    move_collector_if.master bus
);
    localparam int SEL_W     = $clog2(NUM_SQ);
    localparam int SLOT_W    = $clog2(SLOTS);
    localparam int WD_W      = $clog2(WAIT_MAX);
    localparam int WORD_W    = MOVE_W * SLOTS;
    localparam int STALE_CYC = 2;
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SQ - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WAIT_MAX - 1);
    localparam logic [NUM_SQ-1:0] SQ_ONE    = {{(NUM_SQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WAIT, S_SCAN, S_READ, S_LATCH, S_EMIT, S_FIN
    } state_t;

    state_t                          r_state, w_state_nxt;
    logic [SEL_W-1:0]                r_sel, w_sel_nxt;
    logic [SLOT_W-1:0]               r_slot, w_slot_nxt;
    logic [SLOTS-1:0][MOVE_W-1:0]    r_word, w_word_nxt;
    logic [WD_W-1:0]                 r_wd, w_wd_nxt;
    logic                            r_timeout, w_timeout_nxt;
    logic [8:0]                      r_count, w_count_nxt;
    logic                            r_busy, r_gen_done, r_sq_reset, r_mv_valid;
    logic [NUM_SQ-1:0]               r_rden;
    logic [MOVE_W-1:0]               r_mv_data;
    logic [MOVE_W-1:0]               w_move_nxt;
    logic                            w_emit_nxt;
    logic                            w_advance;
    logic                            w_unused_hi;

    assign w_unused_hi = ^bus.sq_fifo_q[FIFO_W-1:WORD_W];

    // Next-state and datapath update for the sequencing FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_slot_nxt    = r_slot;
        w_word_nxt    = r_word;
        w_wd_nxt      = r_wd;
        w_timeout_nxt = r_timeout;
        w_count_nxt   = r_count;
        w_advance     = !r_mv_valid || bus.mv_ready;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = S_RST;
                    w_timeout_nxt = 1'b0;
                    w_count_nxt   = 9'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RST: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Done flags are stale for the first cycles after the array reset
                if ((r_wd >= WD_W'(STALE_CYC)) && (&bus.sq_done)) begin
                    w_state_nxt = S_SCAN;
                    w_sel_nxt   = '0;
                end else if (r_wd == WD_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_SCAN;
                    w_sel_nxt     = '0;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            S_SCAN: begin
                if (!bus.sq_fifo_empty[r_sel]) begin
                    w_state_nxt = S_READ;
                end else if (r_sel != SEL_LAST) begin
                    w_sel_nxt = r_sel + SEL_W'(1);
                end else begin
                    w_state_nxt = S_FIN;
                end
            end
            S_READ:  w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_word_nxt  = bus.sq_fifo_q[WORD_W-1:0];
                w_slot_nxt  = SLOT_LAST;
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (w_advance) begin
                    if (r_mv_valid && (r_count != 9'h1FF)) begin
                        w_count_nxt = r_count + 9'd1;
                    end else begin
                        w_count_nxt = r_count;
                    end
                    if (r_slot == '0) begin
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_slot_nxt = r_slot - SLOT_W'(1);
                    end
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_move_nxt = w_word_nxt[w_slot_nxt];
    assign w_emit_nxt = (w_state_nxt == S_EMIT) && !w_move_nxt[MOVE_W-1];

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_slot    <= '0;
            r_word    <= '0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_count   <= 9'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_slot    <= w_slot_nxt;
            r_word    <= w_word_nxt;
            r_wd      <= w_wd_nxt;
            r_timeout <= w_timeout_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Outputs registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy     <= 1'b0;
            r_sq_reset <= 1'b0;
            r_gen_done <= 1'b0;
            r_rden     <= '0;
            r_mv_valid <= 1'b0;
            r_mv_data  <= '0;
        end else begin
            r_busy     <= (w_state_nxt != S_IDLE);
            r_sq_reset <= (w_state_nxt == S_RST);
            r_gen_done <= (w_state_nxt == S_FIN);
            r_rden     <= (w_state_nxt == S_READ) ? (SQ_ONE << w_sel_nxt) : '0;
            r_mv_valid <= w_emit_nxt;
            r_mv_data  <= w_emit_nxt ? w_move_nxt : '0;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.gen_done   = r_gen_done;
    assign bus.timeout    = r_timeout;
    assign bus.move_count = r_count;
    assign bus.sq_reset   = r_sq_reset;
    assign bus.sq_sel     = r_sel;
    assign bus.sq_rden    = r_rden;
    assign bus.mv_valid   = r_mv_valid;
    assign bus.mv_data    = r_mv_data;
endmodule

// File: tb/tb_move_collector.sv
// Randomized bench for move_collector: a FIFO-array model feeds the DUT and a
// list-based reference predicts the move stream, counts, flags and run length.
module tb_move_collector;
    localparam int NUM_SQ   = 64;
    localparam int MOVE_W   = 19;
    localparam int SLOTS    = 8;
    localparam int FIFO_W   = 160;
    localparam int WAIT_MAX = 32;
    localparam int WORD_W   = MOVE_W * SLOTS;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    move_collector_if #(.NUM_SQ(NUM_SQ), .MOVE_W(MOVE_W), .FIFO_W(FIFO_W)) bus ();

    move_collector #(.NUM_SQ(NUM_SQ), .MOVE_W(MOVE_W), .SLOTS(SLOTS),
                     .FIFO_W(FIFO_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [FIFO_W-1:0] mem [NUM_SQ][DEPTH];
    int wr_cnt [NUM_SQ];
    int rd_cnt [NUM_SQ];
    int rden_hits [NUM_SQ];
    int rden_bad = 0;
    int sqrst_pulses = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Square array FIFO model: empty flags and one-cycle read latency
    always_comb begin
        for (int i = 0; i < NUM_SQ; i++) bus.sq_fifo_empty[i] = (rd_cnt[i] >= wr_cnt[i]);
    end

    always @(posedge clk) begin
        if (bus.sq_reset) sqrst_pulses++;
        if (bus.sq_rden != '0) begin
            if ($countones(bus.sq_rden) != 1) rden_bad++;
            for (int i = 0; i < NUM_SQ; i++) begin
                if (bus.sq_rden[i]) begin
                    bus.sq_fifo_q <= mem[i][rd_cnt[i] % DEPTH];
                    rd_cnt[i]++;
                    rden_hits[i]++;
                end
            end
        end
    end

    task automatic clear_fifos();
        for (int i = 0; i < NUM_SQ; i++) wr_cnt[i] = rd_cnt[i];
    endtask

    task automatic push_word(input int sq, input logic [FIFO_W-1:0] w);
        mem[sq][wr_cnt[sq] % DEPTH] = w;
        wr_cnt[sq]++;
    endtask

    function automatic logic [FIFO_W-1:0] rand_word(input int valid_pct);
        logic [SLOTS-1:0][MOVE_W-1:0] sl;
        for (int s = 0; s < SLOTS; s++) begin
            sl[3'(s)] = MOVE_W'($urandom());
            sl[3'(s)][MOVE_W-1] = ($urandom_range(0, 99) >= valid_pct);
        end
        return {8'($urandom()), sl};
    endfunction

    function automatic logic [FIFO_W-1:0] single_word();
        logic [SLOTS-1:0][MOVE_W-1:0] sl;
        for (int s = 0; s < SLOTS; s++) sl[3'(s)] = 19'h40000 | MOVE_W'($urandom() & 32'h3FFFF);
        sl[7] = {7'b0000000, 6'o14, 6'o24};
        sl[3] = {7'b0000001, 6'o14, 6'o25};
        return {8'h00, sl};
    endfunction

    // mode 0: ready always high, 1: first move stalled 5 cycles, 2: random ready
    task automatic run_and_check(input string tag, input int mode,
                                 input logic [NUM_SQ-1:0] done_mask, input bit poke_start);
        logic [MOVE_W-1:0] exp_q[$];
        logic [SLOTS-1:0][MOVE_W-1:0] sl;
        logic [MOVE_W-1:0] prev_data;
        int words [NUM_SQ];
        int hits0 [NUM_SQ];
        int exp_cyc, exp_cnt, got, cyc, stall_left, bad, rst0, rbad0;
        bit done_seen, prev_stall, rdy;

        exp_cyc = 1 + ((&done_mask) ? 3 : WAIT_MAX) + 1 + ((mode == 1) ? 5 : 0);
        for (int sq = 0; sq < NUM_SQ; sq++) begin
            words[sq] = wr_cnt[sq] - rd_cnt[sq];
            exp_cyc += 11 * words[sq] + 1;
            for (int w = 0; w < words[sq]; w++) begin
                sl = mem[sq][(rd_cnt[sq] + w) % DEPTH][WORD_W-1:0];
                for (int s = SLOTS - 1; s >= 0; s--) begin
                    if (!sl[3'(s)][MOVE_W-1]) exp_q.push_back(sl[3'(s)]);
                end
            end
        end
        exp_cnt = (exp_q.size() > 511) ? 511 : exp_q.size();
        hits0 = rden_hits;
        rst0 = sqrst_pulses;
        rbad0 = rden_bad;
        bus.sq_done = done_mask;
        bus.mv_ready = 1'b1;

        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check_val({tag, "_rst_cycle"}, {bus.busy, bus.sq_reset}, 2'b11);
        cyc = 1; got = 0; done_seen = 0; prev_stall = 0; prev_data = '0;
        stall_left = (mode == 1) ? 5 : 0;
        while (!done_seen && cyc <= 4000) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = !(bus.mv_valid && stall_left > 0);
            else rdy = 1'($urandom_range(0, 1));
            if (mode == 1 && bus.mv_valid && stall_left > 0) stall_left--;
            bus.mv_ready = rdy;
            bus.start = poke_start && (cyc == 10 || cyc == 40);
            if (prev_stall) check_val({tag, "_hold"}, {bus.mv_valid, bus.mv_data}, {1'b1, prev_data});
            if (bus.mv_valid) begin
                if (got < exp_q.size()) check_val({tag, "_mv_data"}, bus.mv_data, exp_q[got]);
                else check_val({tag, "_extra_move"}, got, exp_q.size());
                check_val({tag, "_count_live"}, bus.move_count, (got > 511) ? 511 : got);
                prev_stall = !rdy;
                prev_data = bus.mv_data;
                if (rdy) got++;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.gen_done) begin
                done_seen = 1'b1;
                if (mode != 2) check_val({tag, "_done_cycle"}, cyc, exp_cyc);
                check_val({tag, "_busy_at_done"}, bus.busy, 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        check_val({tag, "_gen_done_seen"}, done_seen, 1);
        check_val({tag, "_moves"}, got, exp_q.size());
        check_val({tag, "_move_count"}, bus.move_count, exp_cnt);
        check_val({tag, "_timeout"}, bus.timeout, !(&done_mask));
        bad = 0;
        for (int sq = 0; sq < NUM_SQ; sq++) if (rden_hits[sq] - hits0[sq] != words[sq]) bad++;
        check_val({tag, "_rden_per_sq"}, bad, 0);
        check_val({tag, "_rden_onehot"}, rden_bad - rbad0, 0);
        check_val({tag, "_sq_reset_pulses"}, sqrst_pulses - rst0, 1);
        @(negedge clk);
        check_val({tag, "_idle_after"}, {bus.busy, bus.gen_done, bus.mv_valid}, 3'b000);
    endtask

    initial begin
        logic [NUM_SQ-1:0] mask;
        bit found;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.mv_ready = 1'b1;
        bus.sq_done = '1;
        #1;
        check_val("reset_flags", {bus.busy, bus.gen_done, bus.timeout, bus.sq_reset, bus.mv_valid}, 5'b0);
        check_val("reset_count", bus.move_count, 0);
        check_val("reset_sel_rden", {26'd0, bus.sq_sel}, 0);
        check_val("reset_rden", |bus.sq_rden, 0);
        check_val("reset_mv_data", bus.mv_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        clear_fifos();
        run_and_check("empty", 0, '1, 1'b0);

        clear_fifos();
        push_word(12, single_word());
        run_and_check("single", 0, '1, 1'b0);

        clear_fifos();
        push_word(12, single_word());
        run_and_check("backpressure", 1, '1, 1'b0);

        clear_fifos();
        push_word(0, rand_word(100));
        push_word(0, rand_word(100));
        begin
            logic [SLOTS-1:0][MOVE_W-1:0] sl;
            for (int s = 0; s < SLOTS; s++) sl[3'(s)] = 19'h40000;
            sl[3'($urandom_range(0, 7))] = MOVE_W'($urandom() & 32'h3FFFF);
            push_word(63, {8'hA5, sl});
        end
        run_and_check("multiword", 0, '1, 1'b0);

        clear_fifos();
        push_word(5, rand_word(50));
        push_word(40, rand_word(50));
        mask = '1;
        mask[5] = 1'b0;
        run_and_check("watchdog", 0, mask, 1'b0);

        for (int it = 0; it < 3; it++) begin
            clear_fifos();
            for (int sq = 0; sq < NUM_SQ; sq++) begin
                if ($urandom_range(0, 3) == 0) begin
                    for (int w = 0; w < $urandom_range(1, 2); w++) push_word(sq, rand_word(50));
                end
            end
            run_and_check("random", 2, '1, 1'b0);
        end

        clear_fifos();
        for (int sq = 0; sq < NUM_SQ; sq++) push_word(sq, rand_word(100));
        push_word(0, rand_word(100));
        run_and_check("saturate", 0, '1, 1'b0);

        clear_fifos();
        push_word(12, single_word());
        bus.sq_done = '1;
        bus.mv_ready = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (bus.mv_valid) found = 1'b1;
            else @(negedge clk);
        end
        check_val("arst_reached_emit", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_flags", {bus.busy, bus.gen_done, bus.timeout, bus.sq_reset, bus.mv_valid}, 5'b0);
        check_val("arst_count_sel", {bus.move_count, 17'd0, bus.sq_sel}, 0);
        check_val("arst_rden_data", {|bus.sq_rden, bus.mv_data}, 0);
        repeat (3) @(negedge clk);
        check_val("arst_held", {bus.mv_valid, |bus.sq_rden}, 2'b00);
        reset_n = 1'b1;
        clear_fifos();
        bus.mv_ready = 1'b1;
        run_and_check("post_reset", 0, '1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
- Sequences the 64-square move-generation array for one search ply.
- Pulses the array reset and waits for every square to report done, with a watchdog.
- Then drains each square's move FIFO in square-index order, unpacks the 8 packed 19-bit move slots per FIFO word, and streams only valid moves out over a valid/ready handshake.
- Sits between the square array and the move-evaluation/search logic.

Parameters:
- NUM_SQ, 64, number of square units (index = {xpos,ypos}).
- MOVE_W, 19, move width: [7b flag][6b from][6b to]; flag MSB = invalid.
- SLOTS, 8, move slots per FIFO word.
- FIFO_W, 160, square FIFO word width (bits 159:152 unused).
- WAIT_MAX, 32, watchdog cycles allowed in WAIT.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to generate moves for the current board.
- busy  out  1  high from accepting start until return to IDLE.
- gen_done  out  1  one-cycle pulse when all moves have been emitted.
- timeout  out  1  sticky; set if the watchdog expired this run; cleared on accepted start.
- move_count  out  9  valid moves emitted this run; cleared on accepted start.
- sq_reset  out  1  active-high synchronous reset to all square units.
- sq_done  in  NUM_SQ  per-square done flags.
- sq_fifo_empty  in  NUM_SQ  per-square FIFO empty flags.
- sq_sel  out  6  index of the square whose FIFO output is muxed onto sq_fifo_q.
- sq_rden  out  NUM_SQ  one-hot FIFO read enable.
- sq_fifo_q  in  FIFO_W  muxed FIFO output of square sq_sel; valid the cycle after rden.
- mv_valid  out  1  move output valid.
- mv_data  out  MOVE_W  move word.
- mv_ready  in  1  downstream accepts a move.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE.
  - All outputs are 0: busy, gen_done, timeout, move_count, sq_reset, sq_sel, sq_rden, mv_valid, mv_data.
  - Internal word register, slot counter and watchdog counter are 0.
  - Reset mid-run abandons the run; no further rden or mv_valid is issued.
- IDLE:
  - start=1 → RST; clear timeout and move_count; busy=1.
  - start is ignored in every other state.
- RST:
  - sq_reset=1 for exactly 1 cycle → WAIT; watchdog counter=0.
- WAIT:
  - Ignore sq_done during the first 2 WAIT cycles, because squares still hold stale done.
  - Afterwards, &sq_done=1 → SCAN with sq_sel=0.
  - Watchdog counter increments each cycle. Reaching WAIT_MAX-1 without all done → set timeout=1, → SCAN anyway.
- SCAN:
  - sq_fifo_empty[sq_sel]=0 → READ.
  - Empty and sq_sel<63 → sq_sel+1, stay in SCAN (1 cycle per empty square).
  - Empty and sq_sel=63 → FIN.
- READ:
  - sq_rden = one-hot(sq_sel) for exactly 1 cycle → LATCH.
- LATCH:
  - Capture sq_fifo_q[151:0] into the word register; slot=7 → EMIT.
- EMIT: examines slot k = word[19k+18:19k].
  - Bit 18 = 1 (invalid) → skip in 1 cycle, mv_valid=0.
  - Otherwise drive mv_valid=1, mv_data=slot, and hold both stable until mv_ready=1.
  - On the handshake cycle, move_count+1 (saturates at 511).
  - After slot 0 is done → SCAN with the same sq_sel, so a FIFO holding several words drains fully before advancing.
  - mv_valid never drops without a handshake except on reset.
- FIN:
  - gen_done=1 for 1 cycle; busy=0 from the next cycle → IDLE.
- Ordering:
  - Squares are drained in ascending sq_sel.
  - Within a word, slots go 7 down to 0.
  - Words within a square go in FIFO order.
- Latency per non-empty word: 1 (SCAN) + 1 (READ) + 1 (LATCH) + 8 slot cycles, plus any ready stalls.
- Minimum run with all FIFOs empty: 1 RST + 3 WAIT + 64 SCAN + 1 FIN.

Test Plan:
- Empty FIFOs: start; sq_done all 1 from the cycle after sq_reset; all FIFOs empty → no mv_valid; gen_done 69 cycles after start accepted; move_count=0; timeout=0.
- Single square: sq 12 holds one word with slots 7 and 3 valid ({7'b0,6'o14,6'o24} and {7'b0000001,6'o14,6'o25}), mv_ready=1 → exactly 2 moves in that order; sq_rden=bit 12 pulsed once; move_count=2.
- Backpressure: same as the single-square case with mv_ready=0 for 5 cycles on the first move → mv_valid/mv_data stable for 6 cycles; count increments only at the handshake.
- Multi-word FIFO: sq 0 holds 2 words with 8 valid moves each, sq 63 holds 1 word with 1 valid move → 17 moves; all sq 0 moves precede sq 63; move_count=17.
- Watchdog: sq_done[5] stuck at 0 → timeout=1 after 32 WAIT cycles; draining still occurs; gen_done pulses.
- Async reset: assert reset_n=0 during EMIT → outputs 0 immediately. Then start again → clean run; start pulsed while busy has no effect.
